// File: rtl/xoro_bus_pkg.sv
// Shared definitions for the native-bus peripherals: register indices,
// the timer window base and the byte-strobe merge helper.
package xoro_bus_pkg;

    localparam logic [1:0]  REG_COUNT_LO = 2'd0;
    localparam logic [1:0]  REG_COUNT_HI = 2'd1;
    localparam logic [1:0]  REG_CMP_LO   = 2'd2;
    localparam logic [1:0]  REG_CMP_HI   = 2'd3;

    localparam logic [31:0] TIMER_BASE   = 32'hffff0030;

    // Replace each byte lane whose strobe is set; untouched lanes keep old data.
    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE: tick is high for one cycle every PRESCALE cycles,
// and the phase restarts from zero whenever clear is asserted.
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    // With PRESCALE == 1 the counter is pinned at zero, so tick is constant high.
    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_responder.sv
// 64-bit memory-mapped timer (count, compare, level irq) on the native CPU bus.
// Build option: define TIMER_SNAPSHOT_EN for an atomic LO-then-HI count read.
module timer_responder
    import xoro_bus_pkg::*;
#(
    parameter int          PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hffff_ffff_ffff_ffff
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_irq;
    logic [63:0] r_count;
    logic [63:0] r_cmp;

    logic        w_access;
    logic        w_write;
    logic [1:0]  w_idx;
    logic        w_cnt_lo_wr;
    logic        w_cnt_hi_wr;
    logic        w_cnt_lo_rd;
    logic        w_tick;
    logic [31:0] w_count_hi_rd;
    logic [31:0] w_rd_val;
    logic [63:0] w_count_nxt;
    logic [63:0] w_cmp_nxt;
    logic        w_unused_addr;

    assign w_unused_addr = ^{mem_addr[31:4], mem_addr[1:0]};

    // The !r_ready term makes the cycle after a response deaf to a still-held valid.
    assign w_access    = enable && mem_valid && !r_ready;
    assign w_write     = |mem_wstrb;
    assign w_idx       = mem_addr[3:2];
    assign w_cnt_lo_wr = w_access && w_write && (w_idx == REG_COUNT_LO);
    assign w_cnt_hi_wr = w_access && w_write && (w_idx == REG_COUNT_HI);
    assign w_cnt_lo_rd = w_access && !w_write && (w_idx == REG_COUNT_LO);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .clear  (w_cnt_lo_wr || w_cnt_hi_wr),
        .tick   (w_tick)
    );

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] r_shadow;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shadow <= '0;
        end else if (w_cnt_hi_wr) begin
            r_shadow <= wstrb_merge(r_count[63:32], mem_wdata, mem_wstrb);
        end else if (w_cnt_lo_rd) begin
            r_shadow <= r_count[63:32];
        end
    end

    assign w_count_hi_rd = r_shadow;
`else
    logic w_unused_lo_rd;
    assign w_unused_lo_rd = w_cnt_lo_rd;
    assign w_count_hi_rd  = r_count[63:32];
`endif

    always_comb begin
        w_rd_val = '0;
        case (w_idx)
            REG_COUNT_LO: w_rd_val = r_count[31:0];
            REG_COUNT_HI: w_rd_val = w_count_hi_rd;
            REG_CMP_LO:   w_rd_val = r_cmp[31:0];
            REG_CMP_HI:   w_rd_val = r_cmp[63:32];
            default:      w_rd_val = '0;
        endcase
    end

    // A count write beats the increment; the unwritten half holds its pre-edge value.
    always_comb begin
        w_count_nxt = r_count;
        if (w_cnt_lo_wr) begin
            w_count_nxt = {r_count[63:32], wstrb_merge(r_count[31:0], mem_wdata, mem_wstrb)};
        end else if (w_cnt_hi_wr) begin
            w_count_nxt = {wstrb_merge(r_count[63:32], mem_wdata, mem_wstrb), r_count[31:0]};
        end else if (w_tick) begin
            w_count_nxt = r_count + 64'd1;
        end
    end

    always_comb begin
        w_cmp_nxt = r_cmp;
        if (w_access && w_write && (w_idx == REG_CMP_LO)) begin
            w_cmp_nxt[31:0] = wstrb_merge(r_cmp[31:0], mem_wdata, mem_wstrb);
        end else if (w_access && w_write && (w_idx == REG_CMP_HI)) begin
            w_cmp_nxt[63:32] = wstrb_merge(r_cmp[63:32], mem_wdata, mem_wstrb);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
            r_count <= '0;
            r_cmp   <= CMP_RESET;
        end else begin
            r_ready <= w_access;
            // Zero outside the response cycle so the decoder may OR read buses.
            r_rdata <= (w_access && !w_write) ? w_rd_val : 32'd0;
            r_irq   <= (r_count >= r_cmp);
            r_count <= w_count_nxt;
            r_cmp   <= w_cmp_nxt;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign irq       = r_irq;

endmodule

// File: tb/tb_timer_responder.sv
// Scoreboard bench for timer_responder: a cycle model pushes expected read
// data on each accepted access; a monitor pops and compares on every mem_ready.
module tb_timer_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    timer_responder #(
        .PRESCALE  (1),
        .CMP_RESET (64'hffff_ffff_ffff_ffff)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Reference model, PRESCALE = 1: count advances every cycle unless written.
    logic [63:0] m_count = 64'd0;
    logic [63:0] m_cmp   = '1;
    logic [31:0] m_shadow = 32'd0;
    logic        m_ready = 1'b0;
    logic [31:0] exp_q[$];

    initial begin
        logic        acc;
        logic [1:0]  idx;
        logic [63:0] cn;
        logic [31:0] rv;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_count = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_ready = 1'b0;
                exp_q.delete();
            end else begin
                acc = enable && mem_valid && !m_ready;
                idx = mem_addr[3:2];
                cn  = m_count + 64'd1;
                if (acc && mem_wstrb == 4'd0) begin
                    case (idx)
                        2'd0: begin rv = m_count[31:0]; m_shadow = m_count[63:32]; end
`ifdef TIMER_SNAPSHOT_EN
                        2'd1: rv = m_shadow;
`else
                        2'd1: rv = m_count[63:32];
`endif
                        2'd2: rv = m_cmp[31:0];
                        default: rv = m_cmp[63:32];
                    endcase
                    exp_q.push_back(rv);
                end else if (acc) begin
                    exp_q.push_back(32'd0);
                    case (idx)
                        2'd0: cn = {m_count[63:32], merge(m_count[31:0], mem_wdata, mem_wstrb)};
                        2'd1: begin
                            cn = {merge(m_count[63:32], mem_wdata, mem_wstrb), m_count[31:0]};
                            m_shadow = cn[63:32];
                        end
                        2'd2: m_cmp[31:0]  = merge(m_cmp[31:0], mem_wdata, mem_wstrb);
                        default: m_cmp[63:32] = merge(m_cmp[63:32], mem_wdata, mem_wstrb);
                    endcase
                end
                m_count = cn;
                m_ready = acc;
            end
        end
    end

    // Monitor: every ready pulse consumes one expectation; idle rdata must be 0.
    initial begin
        logic prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (mem_ready) begin
                    n_pulses++;
                    chk("ready_width", {63'd0, prev_ready}, 64'd0);
                    if (exp_q.size() == 0) chk("spurious_ready", 64'd1, 64'd0);
                    else chk("rdata", {32'd0, mem_rdata}, {32'd0, exp_q.pop_front()});
                end else begin
                    chk("rdata_idle", {32'd0, mem_rdata}, 64'd0);
                end
            end
            prev_ready = mem_ready;
        end
    end

    task automatic bus(input logic [1:0] idx, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, input logic [1:0] lowbits = 2'd0);
        int lat;
        @(negedge clk);
        enable = 1'b1; mem_valid = 1'b1;
        mem_addr = 32'hffff0030 | {28'd0, idx, lowbits};
        mem_wdata = wd; mem_wstrb = ws;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_ready && lat < 8);
        chk("latency", 64'(lat), 64'd1);
        rd = mem_rdata;
        enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          p0;
        int          wcnt;
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, mem_ready}, 64'd0);
        chk("reset_rdata", {32'd0, mem_rdata}, 64'd0);
        chk("reset_irq",   {63'd0, irq}, 64'd0);
        resetn = 1'b1;

        // Idle count after reset
        repeat (10) @(negedge clk);
        bus(2'd0, 32'd0, 4'd0, rd);
        chk("count_after_idle", {63'd0, (rd >= 32'd10 && rd <= 32'd13)}, 64'd1);
        bus(2'd3, 32'd0, 4'd0, rd, 2'd3);
        chk("cmp_hi_reset", {32'd0, rd}, 64'hffffffff);

        // Held valid: one pulse per acceptance, accepted every other cycle
        p0 = n_pulses;
        @(negedge clk);
        enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'hffff0030;
        mem_wdata = 32'h100; mem_wstrb = 4'hf;
        repeat (5) @(negedge clk);
        enable = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
        repeat (2) @(negedge clk);
        chk("held_valid_pulses", 64'(n_pulses - p0), 64'd3);
        bus(2'd0, 32'd0, 4'd0, rd);

        // enable low: no response
        p0 = n_pulses;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'hffff0030; mem_wdata = 32'h5; mem_wstrb = 4'hf;
        repeat (5) @(negedge clk);
        mem_valid = 1'b0; mem_wstrb = 4'd0;
        chk("enable_low_pulses", 64'(n_pulses - p0), 64'd0);

        // Compare / irq
        bus(2'd0, 32'd0, 4'hf, rd);
        bus(2'd3, 32'd0, 4'hf, rd);
        bus(2'd2, 32'h20, 4'hf, rd);
        chk("irq_below_cmp", {63'd0, irq}, 64'd0);
        wcnt = 0;
        while (m_count != 64'h20 && wcnt < 100) begin
            @(negedge clk);
            wcnt++;
        end
        chk("irq_wait", {63'd0, (m_count == 64'h20)}, 64'd1);
        chk("irq_at_match", {63'd0, irq}, 64'd0);
        @(negedge clk);
        chk("irq_rise", {63'd0, irq}, 64'd1);
        bus(2'd2, 32'hffffffff, 4'hf, rd);
        @(negedge clk);
        chk("irq_fall", {63'd0, irq}, 64'd0);

        // Wrap
        bus(2'd1, 32'hffffffff, 4'hf, rd);
        bus(2'd0, 32'hfffffffe, 4'hf, rd);
        repeat (3) @(negedge clk);
        bus(2'd1, 32'd0, 4'd0, rd);
        chk("wrap_hi", {32'd0, rd}, 64'd0);
        bus(2'd0, 32'd0, 4'd0, rd);

        // Byte-lane write while ticking
        bus(2'd0, 32'h0000ab00, 4'b0010, rd);
        bus(2'd0, 32'd0, 4'd0, rd);
        chk("merge_byte1", {56'd0, rd[15:8]}, 64'hab);

        // LO-then-HI read across a carry
        bus(2'd1, 32'd1, 4'hf, rd);
        bus(2'd0, 32'hfffffff0, 4'hf, rd);
        bus(2'd0, 32'd0, 4'd0, rd);
        repeat (20) @(negedge clk);
        bus(2'd1, 32'd0, 4'd0, rd);
`ifdef TIMER_SNAPSHOT_EN
        chk("snapshot_hi", {32'd0, rd}, 64'd1);
`else
        chk("live_hi", {32'd0, rd}, 64'd2);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
